// File: rtl/alu_chain_seq_if.sv
// Shared word/ALU types and the handshake bundle between alu_chain_seq and its neighbours.
// The slave modport is the chain sequencer; the master modport is whoever drives it.
package alu_chain_pkg;
    typedef logic [3:0] AluVal;
    localparam int W = $bits(AluVal);

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_AND  = 3'd1,
        ALU_OR   = 3'd2,
        ALU_XOR  = 3'd3,
        ALU_XNOR = 3'd4
    } alu_cmd_e;

    typedef struct packed {
        alu_cmd_e cmd;
        logic     b_inv;
        logic     carry_in;
        logic     carry_disable;
        AluVal    a;
        AluVal    b;
    } AluArgs;

    typedef struct packed {
        AluVal res;
        logic  carry_out;
    } AluRet;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
endpackage

interface alu_chain_seq_if;
    import alu_chain_pkg::*;

    logic       start;
    logic [2:0] op;
    logic [2:0] len;
    logic       busy;
    logic       in_valid;
    logic       in_ready;
    AluVal      in_d1;
    AluVal      in_d2;
    logic       out_valid;
    logic       out_ready;
    AluVal      out_res;
    logic       out_last;
    logic       carry_flag;
    logic       zero_flag;
    logic       done;
    AluArgs     alu_args;
    AluRet      alu_ret;

    modport slave (
        input  start, op, len, in_valid, in_d1, in_d2, out_ready, alu_ret,
        output busy, in_ready, out_valid, out_res, out_last, carry_flag, zero_flag, done, alu_args
    );

    modport master (
        output start, op, len, in_valid, in_d1, in_d2, out_ready, alu_ret,
        input  busy, in_ready, out_valid, out_res, out_last, carry_flag, zero_flag, done, alu_args
    );
endinterface

// File: rtl/alu_chain_seq.sv
// Purpose: sequences a multi-word ADD/SUB/logic op through an external ALU, LS word first.
// Latency: operand handshake to out_valid is 2 cycles; at most one word per 2 cycles.
// Backpressure: one-entry output buffer; a full buffer with out_ready low stalls EXEC.
module alu_chain_seq
    import alu_chain_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    alu_chain_seq_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_FLUSH} state_e;

    state_e     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] len_q, len_d;
    logic [3:0] cnt_q, cnt_d;
    logic       carry_q, carry_d;
    logic       zacc_q, zacc_d;
    AluVal      a_q, a_d;
    AluVal      b_q, b_d;
    logic       out_valid_q, out_valid_d;
    AluVal      out_res_q, out_res_d;
    logic       out_last_q, out_last_d;
    logic       carry_flag_q, carry_flag_d;
    logic       zero_flag_q, zero_flag_d;
    logic       done_q, done_d;
    logic       busy_q, busy_d;
    logic       in_ready_q, in_ready_d;

    logic       is_arith;
    logic       first_word;
    logic       last_word;
    logic       out_accept;
    AluArgs     args;

    assign is_arith   = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign first_word = (cnt_q == 4'd0);
    assign last_word  = (cnt_q == {1'b0, len_q});
    assign out_accept = out_valid_q && bus.out_ready;

    // SUB runs as a + ~b + 1 on word 0, then ripples the carry register as not-borrow.
    always_comb begin
        args               = '0;
        args.a             = a_q;
        args.b             = b_q;
        args.carry_disable = 1'b0;
        case (op_q)
            OP_ADD: begin
                args.cmd      = ALU_ADD;
                args.carry_in = first_word ? 1'b0 : carry_q;
            end
            OP_SUB: begin
                args.cmd      = ALU_ADD;
                args.b_inv    = 1'b1;
                args.carry_in = first_word ? 1'b1 : carry_q;
            end
            OP_AND:  args.cmd = ALU_AND;
            OP_OR:   args.cmd = ALU_OR;
            OP_XOR:  args.cmd = ALU_XOR;
            OP_XNOR: args.cmd = ALU_XNOR;
            default: args.cmd = ALU_ADD;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        carry_d      = carry_q;
        zacc_d       = zacc_q;
        a_d          = a_q;
        b_d          = b_q;
        out_valid_d  = out_accept ? 1'b0 : out_valid_q;
        out_res_d    = out_res_q;
        out_last_d   = out_last_q;
        carry_flag_d = carry_flag_q;
        zero_flag_d  = zero_flag_q;
        done_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && (bus.op <= OP_XNOR)) begin
                    op_d    = bus.op;
                    len_d   = bus.len;
                    cnt_d   = 4'd0;
                    carry_d = 1'b0;
                    zacc_d  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d     = bus.in_d1;
                    b_d     = bus.in_d2;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!out_valid_q || bus.out_ready) begin
                    out_res_d   = bus.alu_ret.res;
                    out_valid_d = 1'b1;
                    out_last_d  = last_word;
                    carry_d     = is_arith ? bus.alu_ret.carry_out : 1'b0;
                    zacc_d      = zacc_q & (bus.alu_ret.res == '0);
                    cnt_d       = cnt_q + 4'd1;
                    state_d     = last_word ? S_FLUSH : S_FETCH;
                end
            end
            S_FLUSH: begin
                if (out_accept && out_last_q) begin
                    carry_flag_d = carry_q;
                    zero_flag_d  = zacc_q;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d     = (state_d != S_IDLE);
        in_ready_d = (state_d == S_FETCH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 3'd0;
            len_q        <= 3'd0;
            cnt_q        <= 4'd0;
            carry_q      <= 1'b0;
            zacc_q       <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            out_valid_q  <= 1'b0;
            out_res_q    <= '0;
            out_last_q   <= 1'b0;
            carry_flag_q <= 1'b0;
            zero_flag_q  <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            carry_q      <= carry_d;
            zacc_q       <= zacc_d;
            a_q          <= a_d;
            b_q          <= b_d;
            out_valid_q  <= out_valid_d;
            out_res_q    <= out_res_d;
            out_last_q   <= out_last_d;
            carry_flag_q <= carry_flag_d;
            zero_flag_q  <= zero_flag_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.alu_args   = args;
    assign bus.busy       = busy_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_res    = out_res_q;
    assign bus.out_last   = out_last_q;
    assign bus.carry_flag = carry_flag_q;
    assign bus.zero_flag  = zero_flag_q;
    assign bus.done       = done_q;

endmodule
